// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped UART transmitter with TX FIFO, 8N1 on tx_o.
// Define UART_TX_PARITY_EN to insert an even-parity bit between data and stop.
module mmio_uart_tx #(
  parameter logic [31:0] BASE_ADDR  = 32'h8000_0000,
  parameter int          CLK_DIV    = 16,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_n_i,
  input  logic        wen_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] data_in_i,
  output logic [31:0] data_out_o,
  output logic        tx_o,
  output logic        busy_o
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(CLK_DIV);
  localparam logic [CW-1:0] DIV_M1 = CW'(CLK_DIV - 1);
  localparam logic [PW:0]   DEPTH  = (PW + 1)'(FIFO_DEPTH);
`ifdef UART_TX_PARITY_EN
  localparam logic PAR_FLAG = 1'b1;
`else
  localparam logic PAR_FLAG = 1'b0;
`endif

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t         state_q, state_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [2:0]     bit_q, bit_d;
  logic [7:0]     shift_q, shift_d;
  logic           tx_q, tx_d;
  logic [7:0]     mem_q [FIFO_DEPTH];
  logic [7:0]     mem_d [FIFO_DEPTH];
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW:0]    count_q, count_d;
  logic           overflow_q, overflow_d;
  logic [31:0]    rdata_q, rdata_d;
`ifdef UART_TX_PARITY_EN
  logic           par_q, par_d;
`endif

  logic        hit, push_req, push, pop, empty, full, clr_ovf;
  logic [1:0]  reg_sel;
  logic [7:0]  head;
  logic        unused_bits;

  assign hit      = (addr_i[31:4] == BASE_ADDR[31:4]);
  assign reg_sel  = addr_i[3:2];
  assign empty    = (count_q == '0);
  assign full     = (count_q == DEPTH);
  assign push_req = wen_i & hit & (reg_sel == 2'd0);
  assign push     = push_req & ~full;
  assign clr_ovf  = wen_i & hit & (reg_sel == 2'd1) & data_in_i[3];
  assign head     = mem_q[rd_ptr_q];
  assign busy_o   = (state_q != S_IDLE) | ~empty;
  assign unused_bits = ^{addr_i[1:0], data_in_i[31:8]};

  assign tx_o       = tx_q;
  assign data_out_o = rdata_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    bit_d      = bit_q;
    shift_d    = shift_q;
    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;
    rdata_d    = 32'h0;
    pop        = 1'b0;
    tx_d       = 1'b1;
`ifdef UART_TX_PARITY_EN
    par_d      = par_q;
`endif

    if (hit && reg_sel == 2'd1)
      rdata_d = {27'h0, PAR_FLAG, overflow_q, busy_o, empty, full};

    // A push against a full FIFO is lost even if the FSM pops this cycle.
    if (push_req && full)
      overflow_d = 1'b1;
    else if (clr_ovf)
      overflow_d = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (!empty) begin
          pop     = 1'b1;
          state_d = S_START;
          cnt_d   = DIV_M1;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_d = S_DATA;
          cnt_d   = DIV_M1;
          bit_d   = 3'd0;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_d = DIV_M1;
          if (bit_q == 3'd7) begin
`ifdef UART_TX_PARITY_EN
            state_d = S_PARITY;
`else
            state_d = S_STOP;
`endif
          end else begin
            bit_d   = bit_q + 3'd1;
            shift_d = {1'b0, shift_q[7:1]};
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_d = S_STOP;
          cnt_d   = DIV_M1;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STOP: begin
        // Back-to-back frames: go straight from stop to the next start bit.
        if (cnt_q == '0) begin
          cnt_d = DIV_M1;
          if (!empty) begin
            pop     = 1'b1;
            state_d = S_START;
          end else begin
            state_d = S_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase

    if (pop) begin
      shift_d  = head;
      rd_ptr_d = rd_ptr_q + PW'(1);
`ifdef UART_TX_PARITY_EN
      par_d    = ^head;
`endif
    end

    if (push) begin
      mem_d[wr_ptr_q] = data_in_i[7:0];
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + (PW + 1)'(1);
      2'b01:   count_d = count_q - (PW + 1)'(1);
      default: count_d = count_q;
    endcase

    case (state_d)
      S_START: tx_d = 1'b0;
      S_DATA:  tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      S_PARITY: tx_d = par_d;
`endif
      default: tx_d = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      bit_q      <= 3'd0;
      shift_q    <= 8'h0;
      tx_q       <= 1'b1;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      rdata_q    <= 32'h0;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 8'h0;
`ifdef UART_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shift_q    <= shift_d;
      tx_q       <= tx_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      rdata_q    <= rdata_d;
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= mem_d[i];
`ifdef UART_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed bench for mmio_uart_tx (CLK_DIV=4, FIFO_DEPTH=4).
module tb_mmio_uart_tx;

  localparam logic [31:0] TXDATA = 32'h8000_0000;
  localparam logic [31:0] STATUS = 32'h8000_0004;
`ifdef UART_TX_PARITY_EN
  localparam int          NBITS  = 11;
  localparam logic [31:0] PF     = 32'h10;
`else
  localparam int          NBITS  = 10;
  localparam logic [31:0] PF     = 32'h0;
`endif
  localparam int FRAME = NBITS * 4;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        wen;
  logic [31:0] addr;
  logic [31:0] din;
  logic [31:0] dout;
  logic        tx;
  logic        busy;

  int vecs = 0;
  int fails = 0;

  mmio_uart_tx #(
    .BASE_ADDR  (32'h8000_0000),
    .CLK_DIV    (4),
    .FIFO_DEPTH (4)
  ) dut (
    .clk_i      (clk),
    .rst_n_i    (rst_n),
    .wen_i      (wen),
    .addr_i     (addr),
    .data_in_i  (din),
    .data_out_o (dout),
    .tx_o       (tx),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vecs++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    wen = 1'b1; addr = a; din = d;
    @(negedge clk);
    wen = 1'b0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    wen = 1'b0; addr = a;
    @(negedge clk);
    chk(tag, dout, exp);
  endtask

  // Line level for sample i of a frame (4 samples per bit time).
  function automatic logic fbit(input logic [7:0] b, input int i);
    int slot;
    slot = i / 4;
    if (slot == 0) return 1'b0;
    if (slot <= 8) return b[slot-1];
`ifdef UART_TX_PARITY_EN
    if (slot == 9) return ^b;
`endif
    return 1'b1;
  endfunction

  task automatic expect_frame(input logic [7:0] b);
    for (int i = 0; i < FRAME; i++) begin
      chk($sformatf("frame_%h_s%0d", b, i), {31'h0, tx}, {31'h0, fbit(b, i)});
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; wen = 1'b0; addr = 32'h0; din = 32'h0;
    repeat (2) @(negedge clk);
    chk("rst_tx", {31'h0, tx}, 32'h1);
    chk("rst_busy", {31'h0, busy}, 32'h0);
    chk("rst_dout", dout, 32'h0);
    rst_n = 1'b1;

    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      chk("idle_line", {30'h0, tx, busy}, 32'h2);
    end
    rd_chk("status_idle", STATUS, 32'h2 | PF);

    // Single byte 0xA5.
    wr(TXDATA, 32'hA5);
    chk("a5_push_tx_high", {31'h0, tx}, 32'h1);
    chk("a5_push_busy", {31'h0, busy}, 32'h1);
    @(negedge clk);
    expect_frame(8'hA5);
    chk("a5_after_line", {30'h0, tx, busy}, 32'h2);

    // Fill FIFO while the line is busy; 5th accepted, 6th dropped.
    wr(TXDATA, 32'h11);
    wr(TXDATA, 32'h22);
    wr(TXDATA, 32'h33);
    wr(TXDATA, 32'h44);
    wr(TXDATA, 32'h55);
    rd_chk("status_full", STATUS, 32'h5 | PF);
    wr(TXDATA, 32'h66);
    rd_chk("status_ovf", STATUS, 32'hD | PF);
    rd_chk("txdata_reads_zero", TXDATA, 32'h0);
    wr(STATUS, 32'h8);
    rd_chk("status_ovf_clr", STATUS, 32'h5 | PF);
    wen = 1'b0; addr = 32'h0;
    for (int i = 0; i < 2000; i++) begin
      if (!busy) break;
      @(negedge clk);
    end
    chk("drain_busy", {31'h0, busy}, 32'h0);
    rd_chk("status_drained", STATUS, 32'h2 | PF);

    // Two queued bytes: second start bit directly after first stop bit.
    wr(TXDATA, 32'h3B);
    wr(TXDATA, 32'hC4);
    expect_frame(8'h3B);
    expect_frame(8'hC4);
    chk("b2b_after_line", {30'h0, tx, busy}, 32'h2);

    // Reset during data bit 3 of 0x55 with a second byte queued.
    wr(TXDATA, 32'h55);
    wr(TXDATA, 32'hAA);
    repeat (17) @(negedge clk);
    chk("pre_rst_bit3", {31'h0, tx}, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("rst_mid_tx", {31'h0, tx}, 32'h1);
    chk("rst_mid_busy", {31'h0, busy}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    rd_chk("status_after_rst", STATUS, 32'h2 | PF);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("rst_discard_line", {30'h0, tx, busy}, 32'h2);
    end

    // Misses and reserved registers.
    wr(32'h8000_0010, 32'h77);
    wr(32'h0000_0000, 32'h88);
    wr(32'h8000_0008, 32'h99);
    wr(32'h8000_000C, 32'hAA);
    chk("miss_busy", {31'h0, busy}, 32'h0);
    rd_chk("rd_miss_10", 32'h8000_0010, 32'h0);
    rd_chk("rd_miss_0", 32'h0000_0000, 32'h0);
    rd_chk("rd_rsvd_8", 32'h8000_0008, 32'h0);
    rd_chk("rd_rsvd_c", 32'h8000_000C, 32'h0);
    rd_chk("status_low_bits_ignored", 32'h8000_0007, 32'h2 | PF);
    repeat (4) @(negedge clk);
    chk("miss_line", {30'h0, tx, busy}, 32'h2);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
    $finish;
  end

endmodule
